// File: rtl/banked_regfile.sv
// banked_regfile: multi-port, multi-bank register file with a background bank-clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module banked_regfile #(
    parameter int DATA_W        = 16,
    parameter int REGS_PER_BANK = 16,
    parameter int NUM_BANKS     = 4,
    parameter int NUM_RD_PORTS  = 4,
    parameter int NUM_WR_PORTS  = 2,
    parameter int RA_W          = $clog2(REGS_PER_BANK),
    parameter int BK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic [BK_W-1:0]                  bankSelect_i,
    input  logic [NUM_WR_PORTS-1:0]          wrEnable_i,
    input  logic [NUM_WR_PORTS*RA_W-1:0]     wrAddr_i,
    input  logic [NUM_WR_PORTS*DATA_W-1:0]   wrData_i,
    input  logic [NUM_RD_PORTS-1:0]          rdEnable_i,
    input  logic [NUM_RD_PORTS*RA_W-1:0]     rdAddr_i,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   rdData_o,
    output logic [NUM_RD_PORTS-1:0]          rdValid_o,
    input  logic                             clearReq_i,
    input  logic [BK_W-1:0]                  clearBank_i,
    output logic                             clearBusy_o,
    output logic                             clearDone_o,
    output logic                             wrCollision_o
);
    localparam int DEPTH = NUM_BANKS * REGS_PER_BANK;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    logic [DATA_W-1:0]              mem_q [DEPTH];
    logic [DATA_W-1:0]              mem_d [DEPTH];
    state_t                         state_q, state_d;
    logic [RA_W-1:0]                cnt_q, cnt_d;
    logic [BK_W-1:0]                clr_bank_q, clr_bank_d;
    logic [NUM_RD_PORTS*DATA_W-1:0] rd_q, rd_d;
    logic [NUM_RD_PORTS-1:0]        valid_q;
    logic                           coll_q, coll_d;
    logic                           bank_ok;

    assign bank_ok = int'(bankSelect_i) < NUM_BANKS;

    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_bank_d = clr_bank_q;
        rd_d       = rd_q;
        coll_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clearReq_i && int'(clearBank_i) < NUM_BANKS) begin
                    state_d    = CLEAR;
                    clr_bank_d = clearBank_i;
                    cnt_d      = '0;
                end
            end
            CLEAR: begin
                mem_d[{clr_bank_q, cnt_q}] = '0;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == RA_W'(REGS_PER_BANK - 1)) ? DONE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
        // Port writes follow the clear zeroing so a port write to the same register wins.
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wrEnable_i[w] && bank_ok)
                mem_d[{bankSelect_i, wrAddr_i[w*RA_W +: RA_W]}] = wrData_i[w*DATA_W +: DATA_W];
            for (int v = w + 1; v < NUM_WR_PORTS; v++)
                if (wrEnable_i[w] && wrEnable_i[v] && wrAddr_i[w*RA_W +: RA_W] == wrAddr_i[v*RA_W +: RA_W])
                    coll_d = 1'b1;
        end
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            if (rdEnable_i[r]) begin
                rd_d[r*DATA_W +: DATA_W] = bank_ok ? mem_q[{bankSelect_i, rdAddr_i[r*RA_W +: RA_W]}] : '0;
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR_PORTS; w++)
                    if (bank_ok && wrEnable_i[w] && wrAddr_i[w*RA_W +: RA_W] == rdAddr_i[r*RA_W +: RA_W])
                        rd_d[r*DATA_W +: DATA_W] = wrData_i[w*DATA_W +: DATA_W];
`endif
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_bank_q <= '0;
            rd_q       <= '0;
            valid_q    <= '0;
            coll_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_bank_q <= clr_bank_d;
            rd_q       <= rd_d;
            valid_q    <= rdEnable_i;
            coll_q     <= coll_d;
        end
    end

    assign rdData_o      = rd_q;
    assign rdValid_o     = valid_q;
    assign clearBusy_o   = state_q != IDLE;
    assign clearDone_o   = state_q == DONE;
    assign wrCollision_o = coll_q;
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed table-driven bench for banked_regfile plus clear-engine sequences.
module tb_banked_regfile;
    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [1:0]  bankSelect_i;
    logic [1:0]  wrEnable_i;
    logic [7:0]  wrAddr_i;
    logic [31:0] wrData_i;
    logic [3:0]  rdEnable_i;
    logic [15:0] rdAddr_i;
    logic [63:0] rdData_o;
    logic [3:0]  rdValid_o;
    logic        clearReq_i;
    logic [1:0]  clearBank_i;
    logic        clearBusy_o;
    logic        clearDone_o;
    logic        wrCollision_o;

    int n_checks = 0;
    int n_pass   = 0;

    banked_regfile dut (
        .clock_i(clock_i), .reset_i(reset_i), .bankSelect_i(bankSelect_i),
        .wrEnable_i(wrEnable_i), .wrAddr_i(wrAddr_i), .wrData_i(wrData_i),
        .rdEnable_i(rdEnable_i), .rdAddr_i(rdAddr_i), .rdData_o(rdData_o), .rdValid_o(rdValid_o),
        .clearReq_i(clearReq_i), .clearBank_i(clearBank_i), .clearBusy_o(clearBusy_o),
        .clearDone_o(clearDone_o), .wrCollision_o(wrCollision_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [1:0]  bank;
        logic [1:0]  wen;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  ren;
        logic [15:0] raddr;
        logic [63:0] exp_data;
        logic [3:0]  exp_valid;
        logic        exp_coll;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] BYP7 = 16'hAAAA;
`else
    localparam logic [15:0] BYP7 = 16'h0000;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_inputs();
        wrEnable_i = '0; wrAddr_i = '0; wrData_i = '0;
        rdEnable_i = '0; rdAddr_i = '0; clearReq_i = 1'b0; clearBank_i = '0;
    endtask

    task automatic read1(input logic [1:0] bank, input logic [3:0] addr, output logic [15:0] data);
        bankSelect_i = bank; rdEnable_i = 4'b0001; rdAddr_i = {12'h0, addr};
        tick();
        data = rdData_o[15:0];
        rdEnable_i = '0;
    endtask

    initial begin
        vec_t vecs [10];
        int busy_cycles, done_cycles, done_at;
        logic [15:0] d;
        vecs[0] = '{2'd1, 2'b01, 8'h03, 32'h0000_BEEF, 4'b0000, 16'h0000, 64'h0, 4'b0000, 1'b0};
        vecs[1] = '{2'd1, 2'b00, 8'h00, 32'h0, 4'b0100, 16'h0300, 64'h0000_BEEF_0000_0000, 4'b0100, 1'b0};
        vecs[2] = '{2'd0, 2'b00, 8'h00, 32'h0, 4'b0100, 16'h0300, 64'h0, 4'b0100, 1'b0};
        vecs[3] = '{2'd1, 2'b00, 8'h00, 32'h0, 4'b0001, 16'h0003, 64'h0000_0000_0000_BEEF, 4'b0001, 1'b0};
        vecs[4] = '{2'd0, 2'b11, 8'h55, 32'h2222_1111, 4'b0000, 16'h0000, 64'h0000_0000_0000_BEEF, 4'b0000, 1'b1};
        vecs[5] = '{2'd0, 2'b00, 8'h00, 32'h0, 4'b0010, 16'h0050, 64'h0000_0000_2222_BEEF, 4'b0010, 1'b0};
        vecs[6] = '{2'd0, 2'b01, 8'h07, 32'h0000_AAAA, 4'b1000, 16'h7000, {BYP7, 48'h0000_2222_BEEF}, 4'b1000, 1'b0};
        vecs[7] = '{2'd0, 2'b00, 8'h00, 32'h0, 4'b1000, 16'h7000, 64'hAAAA_0000_2222_BEEF, 4'b1000, 1'b0};
        vecs[8] = '{2'd3, 2'b10, 8'hF0, 32'h1234_0000, 4'b0001, 16'h0000, 64'hAAAA_0000_2222_0000, 4'b0001, 1'b0};
        vecs[9] = '{2'd3, 2'b00, 8'h00, 32'h0, 4'b1111, 16'hFF0F, 64'h1234_1234_0000_1234, 4'b1111, 1'b0};

        reset_i = 1'b1; bankSelect_i = '0;
        idle_inputs();
        tick(); tick();
        reset_i = 1'b0;
        tick();
        chk("reset rdData", rdData_o, 64'h0);
        chk("reset rdValid", 64'(rdValid_o), 64'h0);
        chk("reset busy", 64'(clearBusy_o), 64'h0);
        chk("reset done", 64'(clearDone_o), 64'h0);
        chk("reset collision", 64'(wrCollision_o), 64'h0);

        for (int i = 0; i < 10; i++) begin
            bankSelect_i = vecs[i].bank; wrEnable_i = vecs[i].wen; wrAddr_i = vecs[i].waddr;
            wrData_i = vecs[i].wdata; rdEnable_i = vecs[i].ren; rdAddr_i = vecs[i].raddr;
            tick();
            chk($sformatf("vec%0d rdData", i), rdData_o, vecs[i].exp_data);
            chk($sformatf("vec%0d rdValid", i), 64'(rdValid_o), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d collision", i), 64'(wrCollision_o), 64'(vecs[i].exp_coll));
        end
        idle_inputs();

        // Fill bank 2 with non-zero data, two registers per cycle.
        bankSelect_i = 2'd2; wrEnable_i = 2'b11;
        for (int r = 0; r < 16; r += 2) begin
            wrAddr_i = {4'(r + 1), 4'(r)};
            wrData_i = {16'h2001 + 16'(r), 16'h2000 + 16'(r)};
            tick();
        end
        idle_inputs();
        read1(2'd2, 4'd9, d);
        chk("bank2 fill reg9", 64'(d), 64'h2009);

        clearReq_i = 1'b1; clearBank_i = 2'd2;
        tick();
        clearReq_i = 1'b0;
        busy_cycles = 0; done_cycles = 0; done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            if (clearBusy_o) busy_cycles++;
            if (clearDone_o) begin done_cycles++; done_at = busy_cycles; end
            if (!clearBusy_o) break;
            clearReq_i = (c == 5); clearBank_i = 2'd1;
            tick();
        end
        clearReq_i = 1'b0;
        chk("clear busy cycles", 64'(busy_cycles), 64'd17);
        chk("clear done count", 64'(done_cycles), 64'd1);
        chk("clear done position", 64'(done_at), 64'd17);
        bankSelect_i = 2'd2; rdEnable_i = 4'b1111;
        for (int r = 0; r < 16; r += 4) begin
            rdAddr_i = {4'(r + 3), 4'(r + 2), 4'(r + 1), 4'(r)};
            tick();
            chk($sformatf("bank2 cleared regs %0d..%0d", r, r + 3), rdData_o, 64'h0);
        end
        idle_inputs();
        read1(2'd1, 4'd3, d);
        chk("bank1 untouched by clear", 64'(d), 64'hBEEF);

        // Bank-0 clear with a port-1 write to the register being zeroed that cycle.
        clearReq_i = 1'b1; clearBank_i = 2'd0;
        tick();
        clearReq_i = 1'b0;
        repeat (5) tick();
        bankSelect_i = 2'd0; wrEnable_i = 2'b10; wrAddr_i = 8'h50; wrData_i = 32'h5A5A_0000;
        tick();
        idle_inputs();
        for (int c = 0; c < 40 && clearBusy_o; c++) tick();
        chk("bank0 clear finished", 64'(clearBusy_o), 64'h0);
        read1(2'd0, 4'd5, d);
        chk("write beats clear", 64'(d), 64'h5A5A);
        read1(2'd0, 4'd7, d);
        chk("bank0 reg7 cleared", 64'(d), 64'h0);

        // Reset in the middle of a bank-3 clear at counter 6.
        clearReq_i = 1'b1; clearBank_i = 2'd3;
        tick();
        clearReq_i = 1'b0;
        bankSelect_i = 2'd1; rdEnable_i = 4'b0001; rdAddr_i = 16'h0003;
        repeat (6) tick();
        chk("pre-reset busy", 64'(clearBusy_o), 64'h1);
        chk("pre-reset rdData", rdData_o, 64'h0000_0000_0000_BEEF);
        #2 reset_i = 1'b1;
        #1;
        chk("async reset rdData", rdData_o, 64'h0);
        chk("async reset rdValid", 64'(rdValid_o), 64'h0);
        chk("async reset busy", 64'(clearBusy_o), 64'h0);
        chk("async reset done", 64'(clearDone_o), 64'h0);
        tick();
        reset_i = 1'b0;
        idle_inputs();
        tick(); tick();
        chk("no resume after reset", 64'(clearBusy_o), 64'h0);
        read1(2'd1, 4'd3, d);
        chk("storage cleared bank1", 64'(d), 64'h0);
        read1(2'd3, 4'd15, d);
        chk("storage cleared bank3", 64'(d), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
